// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response handshakes for both ports plus the shared ALU connection.
interface alu_arbiter_if #(parameter int DATA_W = 16);
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DATA_W-1:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
    logic [5:0]        req0_imm, req1_imm;
    logic [2:0]        req0_op, req1_op;
    logic [3:0]        req0_func4, req1_func4;
    logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [DATA_W-1:0] alu_rs1, alu_rs2, alu_result;
    logic [5:0]        alu_imm;
    logic [2:0]        alu_op;
    logic [3:0]        alu_func4;

    modport slave (
        input  req0_valid, req0_rs1, req0_rs2, req0_imm, req0_op, req0_func4,
        input  req1_valid, req1_rs1, req1_rs2, req1_imm, req1_op, req1_func4,
        input  rsp0_ready, rsp1_ready, alu_result,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
        output alu_rs1, alu_rs2, alu_imm, alu_op, alu_func4
    );

    modport master (
        output req0_valid, req0_rs1, req0_rs2, req0_imm, req0_op, req0_func4,
        output req1_valid, req1_rs1, req1_rs2, req1_imm, req1_op, req1_func4,
        output rsp0_ready, rsp1_ready, alu_result,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
        input  alu_rs1, alu_rs2, alu_imm, alu_op, alu_func4
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters,
// one registered command in flight at a time.
module alu_arbiter #(parameter int DATA_W = 16) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_n;
    logic              last_grant, grant_id, grant;
    logic              rsp_done, accept_ok, accept;
    logic [DATA_W-1:0] rs1_q, rs2_q, result_q;
    logic [5:0]        imm_q;
    logic [2:0]        op_q;
    logic [3:0]        func4_q;

    // Only the granted port's rsp_ready can retire the held result.
    assign rsp_done  = (state == RESP) && (grant_id ? bus.rsp1_ready : bus.rsp0_ready);
    assign accept_ok = (state == IDLE) || rsp_done;
    assign grant     = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    assign accept    = accept_ok && (bus.req0_valid || bus.req1_valid);

    assign bus.req0_ready = accept && !grant;
    assign bus.req1_ready = accept && grant;
    assign bus.rsp0_valid = (state == RESP) && !grant_id;
    assign bus.rsp1_valid = (state == RESP) && grant_id;
    assign bus.rsp_data   = result_q;
    assign bus.alu_rs1    = rs1_q;
    assign bus.alu_rs2    = rs2_q;
    assign bus.alu_imm    = imm_q;
    assign bus.alu_op     = op_q;
    assign bus.alu_func4  = func4_q;

    always_comb begin
        state_n = IDLE;
        state_n = (state == EXEC) ? RESP :
                  accept ? EXEC :
                  (state == RESP && !rsp_done) ? RESP : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            op_q       <= '0;
            func4_q    <= '0;
            result_q   <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                last_grant <= grant;
                grant_id   <= grant;
                rs1_q      <= grant ? bus.req1_rs1 : bus.req0_rs1;
                rs2_q      <= grant ? bus.req1_rs2 : bus.req0_rs2;
                imm_q      <= grant ? bus.req1_imm : bus.req0_imm;
                op_q       <= grant ? bus.req1_op : bus.req0_op;
                func4_q    <= grant ? bus.req1_func4 : bus.req0_func4;
            end
            if (state == EXEC) result_q <= bus.alu_result;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors plus multi-cycle sequences against a small ALU stub.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_arbiter_if #(.DATA_W(16)) bus ();
    alu_arbiter #(.DATA_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // ALU stub: op 001 uses the sign-extended immediate as operand B.
    logic [15:0] alu_b;
    always_comb begin
        alu_b = (bus.alu_op == 3'b001) ? {{10{bus.alu_imm[5]}}, bus.alu_imm} : bus.alu_rs2;
        bus.alu_result = (bus.alu_func4 == 4'h0) ? bus.alu_rs1 + alu_b :
                         (bus.alu_func4 == 4'h1) ? bus.alu_rs1 - alu_b :
                         (bus.alu_func4 == 4'h2) ? bus.alu_rs1 & alu_b :
                         (bus.alu_func4 == 4'h3) ? bus.alu_rs1 | alu_b :
                         (bus.alu_func4 == 4'h4) ? bus.alu_rs1 ^ alu_b : 16'h0000;
    end

    typedef struct {
        bit          port;
        logic [15:0] rs1, rs2;
        logic [5:0]  imm;
        logic [2:0]  op;
        logic [3:0]  func4;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input bit p, input logic [15:0] rs1, input logic [15:0] rs2,
                           input logic [5:0] imm, input logic [2:0] op,
                           input logic [3:0] func4, input logic v);
        if (p) begin
            bus.req1_rs1 = rs1; bus.req1_rs2 = rs2; bus.req1_imm = imm;
            bus.req1_op = op; bus.req1_func4 = func4; bus.req1_valid = v;
        end else begin
            bus.req0_rs1 = rs1; bus.req0_rs2 = rs2; bus.req0_imm = imm;
            bus.req0_op = op; bus.req0_func4 = func4; bus.req0_valid = v;
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        set_req(v.port, v.rs1, v.rs2, v.imm, v.op, v.func4, 1'b1);
        @(negedge clk);
        chk("req_ready", {bus.req1_ready, bus.req0_ready}, v.port ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("exec_alu_rs1", bus.alu_rs1, v.rs1);
        chk("exec_alu_cmd", {bus.alu_imm, bus.alu_op, bus.alu_func4}, {v.imm, v.op, v.func4});
        chk("exec_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
        @(negedge clk);
        chk("resp_valid", {bus.rsp1_valid, bus.rsp0_valid}, v.port ? 2'b10 : 2'b01);
        chk("resp_data", bus.rsp_data, v.exp);
        @(negedge clk);
        chk("back_to_idle", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
    endtask

    initial begin
        vecs[0] = '{1'b0, 16'h0005, 16'h0003, 6'h00, 3'b000, 4'h0, 16'h0008};
        vecs[1] = '{1'b1, 16'h0010, 16'h0000, 6'h3F, 3'b001, 4'h0, 16'h000F};
        vecs[2] = '{1'b0, 16'h1234, 16'h4321, 6'h00, 3'b000, 4'hF, 16'h0000};
        vecs[3] = '{1'b1, 16'h0020, 16'h0005, 6'h00, 3'b000, 4'h1, 16'h001B};
        vecs[4] = '{1'b0, 16'hF0F0, 16'hFF00, 6'h00, 3'b000, 4'h2, 16'hF000};

        set_req(1'b0, '0, '0, '0, '0, '0, 1'b0);
        set_req(1'b1, '0, '0, '0, '0, '0, 1'b0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;

        #12;
        chk("reset_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
        chk("reset_rsp_data", bus.rsp_data, 16'h0000);
        chk("reset_alu", {bus.alu_rs1, bus.alu_rs2, bus.alu_imm, bus.alu_op, bus.alu_func4}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Stalled port-0 response with port 1 waiting and a wrong-port rsp1_ready.
        @(posedge clk); #1;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b1;
        set_req(1'b0, 16'h0100, 16'h0023, 6'h00, 3'b000, 4'h0, 1'b1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        set_req(1'b1, 16'h0002, 16'h0003, 6'h00, 3'b000, 4'h0, 1'b1);
        @(negedge clk);
        chk("bp_exec_req1_ready", bus.req1_ready, 1'b0);
        @(negedge clk);
        chk("bp_rsp0_valid", bus.rsp0_valid, 1'b1);
        chk("bp_rsp_data", bus.rsp_data, 16'h0123);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_data", bus.rsp_data, 16'h0123);
            chk("bp_hold_valid", {bus.rsp1_valid, bus.rsp0_valid}, 2'b01);
            chk("bp_req1_blocked", bus.req1_ready, 1'b0);
        end
        @(posedge clk); #1;
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_req1_ready", {bus.req1_ready, bus.rsp0_valid}, 2'b11);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("bp_exec_valid", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
        chk("bp_exec_rs1", bus.alu_rs1, 16'h0002);
        @(negedge clk);
        chk("bp_rsp1_valid", {bus.rsp1_valid, bus.rsp0_valid}, 2'b10);
        chk("bp_rsp1_data", bus.rsp_data, 16'h0005);
        @(negedge clk);
        chk("bp_idle", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);

        // Asynchronous reset during EXEC.
        @(posedge clk); #1;
        set_req(1'b1, 16'h00AA, 16'h0011, 6'h15, 3'b010, 4'h2, 1'b1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_alu", {bus.alu_rs1, bus.alu_rs2, bus.alu_imm, bus.alu_op, bus.alu_func4}, 0);
        chk("mid_rst_rsp_data", bus.rsp_data, 16'h0000);
        chk("mid_rst_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        // Both ports valid continuously: grants alternate starting with port 0.
        set_req(1'b0, 16'h0001, 16'h0001, 6'h00, 3'b000, 4'h0, 1'b1);
        set_req(1'b1, 16'h0010, 16'h0020, 6'h00, 3'b000, 4'h0, 1'b1);
        #1;
        chk("rr_first_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_exec_no_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
            @(negedge clk);
            chk("rr_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, k[0] ? 2'b10 : 2'b01);
            chk("rr_rsp_data", bus.rsp_data, k[0] ? 16'h0030 : 16'h0002);
            if (k < 3)
                chk("rr_next_grant", {bus.req1_ready, bus.req0_ready}, k[0] ? 2'b01 : 2'b10);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("rr_idle", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
